// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU (port 0) and DMA (port 1).
// Optional lock/burst re-grant is enabled by defining TINY16_ARB_LOCK_EN.
module mem_arbiter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MAX_LOCK    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0] i_cpu_wdata,
  input  logic             i_cpu_lock,
  output logic             o_cpu_gnt,
  output logic             o_cpu_ack,
  output logic [WIDTH-1:0] o_cpu_rdata,
  input  logic             i_dma_req,
  input  logic             i_dma_we,
  input  logic [WIDTH-1:0] i_dma_addr,
  input  logic [WIDTH-1:0] i_dma_wdata,
  input  logic             i_dma_lock,
  output logic             o_dma_gnt,
  output logic             o_dma_ack,
  output logic [WIDTH-1:0] o_dma_rdata,
  output logic             o_mem_addr_en,
  output logic             o_mem_in_en,
  output logic             o_mem_out_en,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_busy
);

  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_STATES);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StAck} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic             r_owner;      // 0 = CPU, 1 = DMA; doubles as last_owner
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [CntW-1:0]  r_wait_cnt;
  logic [WIDTH-1:0] r_cpu_rdata;
  logic [WIDTH-1:0] r_dma_rdata;

  logic w_start;
  logic w_pick;
  logic w_data_last;
  logic w_lock_hit;

  assign w_data_last = (r_wait_cnt == WaitLast);

`ifdef TINY16_ARB_LOCK_EN
  localparam int unsigned LockW = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [LockW-1:0] MaxLockVal = LockW'(MAX_LOCK);
  localparam logic [LockW-1:0] LockOne    = LockW'(1);

  logic [LockW-1:0] r_lock_cnt;
  logic             w_last_req;
  logic             w_last_lock;
  logic             w_lock_ignore;
  logic             w_pick_lock;

  assign w_last_req    = r_owner ? i_dma_req  : i_cpu_req;
  assign w_last_lock   = r_owner ? i_dma_lock : i_cpu_lock;
  assign w_lock_ignore = (r_lock_cnt == MaxLockVal);
  assign w_lock_hit    = !w_lock_ignore && w_last_req && w_last_lock;
  assign w_pick_lock   = w_pick ? i_dma_lock : i_cpu_lock;

  // A grant counts as locked when the winner asserts lock; the streak breaks once at MAX_LOCK.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
    end else if (w_start) begin
      if (w_lock_ignore || !w_pick_lock) begin
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + LockOne;
      end
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^{i_cpu_lock, i_dma_lock, MAX_LOCK[0]};
  assign w_lock_hit    = 1'b0;
`endif

  always_comb begin
    w_pick = i_dma_req;
    if (w_lock_hit) begin
      w_pick = r_owner;
    end else if (i_cpu_req && i_dma_req) begin
      w_pick = ~r_owner;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_start       = 1'b0;
    o_mem_addr_en = 1'b0;
    o_mem_in_en   = 1'b0;
    o_mem_out_en  = 1'b0;
    o_cpu_ack     = 1'b0;
    o_dma_ack     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req || i_dma_req) begin
          w_state_d = StAddr;
          w_start   = 1'b1;
        end
      end
      StAddr: begin
        o_mem_addr_en = 1'b1;
        w_state_d     = StData;
      end
      StData: begin
        o_mem_in_en  = r_we;
        o_mem_out_en = !r_we;
        if (w_data_last) begin
          w_state_d = StAck;
        end
      end
      StAck: begin
        o_cpu_ack = !r_owner;
        o_dma_ack = r_owner;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_owner     <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_owner <= w_pick;
        r_we    <= w_pick ? i_dma_we    : i_cpu_we;
        r_addr  <= w_pick ? i_dma_addr  : i_cpu_addr;
        r_wdata <= w_pick ? i_dma_wdata : i_cpu_wdata;
      end
      if (r_state == StAddr) begin
        r_wait_cnt <= '0;
      end else if (r_state == StData && !w_data_last) begin
        r_wait_cnt <= r_wait_cnt + CntOne;
      end
      if (r_state == StData && w_data_last && !r_we) begin
        if (r_owner) begin
          r_dma_rdata <= i_mem_rdata;
        end else begin
          r_cpu_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_cpu_gnt   = o_busy && !r_owner;
  assign o_dma_gnt   = o_busy && r_owner;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dma_rdata = r_dma_rdata;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule
